// File: rtl/led_uart_tx.sv
// led_uart_tx: captures CPU OUT bytes on rising lr into a FIFO and serializes them as UART frames on tx.
// Optional macro LED_UART_PARITY_EN inserts an even-parity bit (8E1); default build is 8N1.
module led_uart_tx #(
  parameter int unsigned CLK_DIV    = 16,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    leds,
  input  logic                          lr,
  output logic                          tx,
  output logic                          busy,
  output logic                          full,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [15:0] BAUD_LAST = 16'(CLK_DIV - 1);

`ifdef LED_UART_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t          r_state;
  logic [15:0]     r_baud;
  logic [2:0]      r_bitcnt;
  logic [7:0]      r_shift;
  logic            r_par;
  logic            r_tx;
  logic            r_busy;
  logic            r_full;
  logic            r_ovf;
  logic            r_lr_d;
  logic [CW-1:0]   r_count;
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [7:0]      r_mem [FIFO_DEPTH];

  logic            w_capture;
  logic            w_pop;
  logic            w_push;
  logic            w_baud_end;
  logic            w_frame_end;
  logic [CW-1:0]   w_count_nxt;

  assign w_capture   = lr & ~r_lr_d;
  assign w_pop       = (r_state == S_IDLE) && (r_count != '0);
  // A pop in the same cycle frees the slot, so a capture into a full FIFO still lands.
  assign w_push      = w_capture && (!r_full || w_pop);
  assign w_baud_end  = (r_state != S_IDLE) && (r_baud == BAUD_LAST);
  assign w_frame_end = (r_state == S_STOP) && w_baud_end;
  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= leds;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lr_d  <= 1'b0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_lr_d  <= lr;
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CW'(FIFO_DEPTH));
      if (w_capture && !w_push) r_ovf <= 1'b1;
      // Registered busy is built from the next-cycle state and occupancy.
      r_busy  <= ((r_state != S_IDLE) && !w_frame_end) || w_pop || (w_count_nxt != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_baud   <= '0;
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_par    <= 1'b0;
      r_tx     <= 1'b1;
    end else begin
      if (w_baud_end) r_baud <= '0;
      else            r_baud <= r_baud + 16'd1;
      case (r_state)
        S_IDLE: begin
          r_baud <= '0;
          r_tx   <= 1'b1;
          if (w_pop) begin
            r_shift  <= r_mem[r_rptr];
            r_par    <= ^r_mem[r_rptr];
            r_bitcnt <= '0;
            r_tx     <= 1'b0;
            r_state  <= S_START;
          end
        end
        S_START: begin
          if (w_baud_end) begin
            r_tx    <= r_shift[0];
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_baud_end) begin
            if (r_bitcnt == 3'd7) begin
`ifdef LED_UART_PARITY_EN
              r_tx    <= r_par;
              r_state <= S_PARITY;
`else
              r_tx    <= 1'b1;
              r_state <= S_STOP;
`endif
            end else begin
              r_bitcnt <= r_bitcnt + 3'd1;
              r_shift  <= {1'b0, r_shift[7:1]};
              r_tx     <= r_shift[1];
            end
          end
        end
`ifdef LED_UART_PARITY_EN
        S_PARITY: begin
          if (w_baud_end) begin
            r_tx    <= 1'b1;
            r_state <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (w_baud_end) begin
            r_tx    <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign tx         = r_tx;
  assign busy       = r_busy;
  assign full       = r_full;
  assign overflow   = r_ovf;
  assign fifo_count = r_count;

endmodule

// File: tb/tb_led_uart_tx.sv
// Scoreboard bench for led_uart_tx: stimulus queues expected bytes, a UART monitor decodes tx and compares.
module tb_led_uart_tx;

  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned DEPTH   = 8;
`ifdef LED_UART_PARITY_EN
  localparam int unsigned NBITS = 11;
`else
  localparam int unsigned NBITS = 10;
`endif
  localparam int unsigned FRAME = NBITS * CLK_DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       lr = 1'b0;
  logic [7:0] leds = '0;
  logic       tx, busy, full, overflow;
  logic [3:0] fifo_count;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  bit         rst_seen = 1'b0;

  always #5 clk = ~clk;

  led_uart_tx #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .leds(leds), .lr(lr), .tx(tx), .busy(busy),
    .full(full), .overflow(overflow), .fifo_count(fifo_count)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic strobe(input logic [7:0] b);
    leds = b;
    lr   = 1'b1;
    @(negedge clk);
    lr   = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_idle(input string name, input int max, output int n);
    n = 0;
    while (busy === 1'b1 && n < max) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) check({name, "_timeout"}, busy, 0);
  endtask

  always @(negedge rst_n) rst_seen = 1'b1;

  initial begin : monitor
    logic [7:0] data;
    logic       ok_start, ok_stop;
`ifdef LED_UART_PARITY_EN
    logic       par;
`endif
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx === 1'b0) begin
        rst_seen = 1'b0;
        repeat (CLK_DIV / 2) @(negedge clk);
        ok_start = (tx === 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (CLK_DIV) @(negedge clk);
          data[i] = tx;
        end
`ifdef LED_UART_PARITY_EN
        repeat (CLK_DIV) @(negedge clk);
        par = tx;
`endif
        repeat (CLK_DIV) @(negedge clk);
        ok_stop = (tx === 1'b1);
        if (!rst_seen) begin
          check("start_bit", ok_start, 1);
          check("stop_bit", ok_stop, 1);
`ifdef LED_UART_PARITY_EN
          check("parity_bit", par, ^data);
`endif
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_frame: got 0x%0h expected no frame at %0t", data, $time);
          end else begin
            check("frame_byte", data, exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int n;
    int peak;

    // reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_full", full, 0);
    check("rst_overflow", overflow, 0);
    check("rst_count", fifo_count, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // single byte 0xA5: start bit two edges after first lr sample
    exp_q.push_back(8'hA5);
    leds = 8'hA5;
    lr   = 1'b1;
    @(negedge clk);
    lr   = 1'b0;
    check("single_count_after_capture", fifo_count, 1);
    check("single_tx_still_idle", tx, 1);
    check("single_busy", busy, 1);
    @(negedge clk);
    check("single_tx_start", tx, 0);
    check("single_count_after_pop", fifo_count, 0);
    wait_idle("single", 200, n);
    check("single_busy_drop_cycles", n, FRAME);

    // held strobe: one capture only
    exp_q.push_back(8'h3C);
    leds = 8'h3C;
    lr   = 1'b1;
    peak = 0;
    repeat (20) begin
      @(negedge clk);
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
    end
    lr = 1'b0;
    check("held_peak_count", peak, 1);
    wait_idle("held", 500, n);

    exp_q.push_back(8'h07);
    strobe(8'h07);
    wait_idle("b07", 500, n);
    exp_q.push_back(8'h03);
    strobe(8'h03);
    wait_idle("b03", 500, n);
    check("no_overflow_yet", overflow, 0);

    // overflow: 10 captures, 0x09 dropped
    for (int i = 0; i < 10; i++) begin
      if (i < 9) exp_q.push_back(8'(i));
      strobe(8'(i));
    end
    check("ovf_flag", overflow, 1);
    check("ovf_count", fifo_count, 8);
    check("ovf_full", full, 1);
    wait_idle("ovf", 1000, n);
    check("ovf_sticky", overflow, 1);
    check("ovf_drained_count", fifo_count, 0);
    check("ovf_drained_full", full, 0);

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ovf_cleared_by_reset", overflow, 0);

    // capture in the same cycle that IDLE pops a full FIFO
    for (int i = 0; i < 9; i++) begin
      exp_q.push_back(8'(8'h10 + i));
      strobe(8'(8'h10 + i));
    end
    repeat (FRAME + 1 - 17) @(negedge clk);
    check("pp_full_before", full, 1);
    check("pp_count_before", fifo_count, 8);
    exp_q.push_back(8'h19);
    leds = 8'h19;
    lr   = 1'b1;
    @(negedge clk);
    lr   = 1'b0;
    check("pp_count_kept", fifo_count, 8);
    check("pp_no_overflow", overflow, 0);
    wait_idle("pp", 1000, n);
    check("pp_no_overflow_end", overflow, 0);

    // reset during DATA bit 3
    exp_q.push_back(8'h5A);
    strobe(8'h5A);
    exp_q.push_back(8'h61);
    strobe(8'h61);
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_tx", tx, 1);
    check("midrst_count", fifo_count, 0);
    check("midrst_busy", busy, 0);
    check("midrst_full", full, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (FRAME + 10) @(negedge clk);
    check("postrst_tx_idle", tx, 1);
    check("postrst_busy", busy, 0);
    exp_q.push_back(8'h55);
    strobe(8'h55);
    wait_idle("postrst", 500, n);
    repeat (4) @(negedge clk);

    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
